// File: rtl/dcache_ctrl_fsm_if.sv
// dcache_ctrl_fsm_if: request, tag-compare, RAM-control and memory-bridge
// signals of the blocking data-cache controller. The slave modport is the
// controller's view; the master modport is the MEM-stage / bridge side.
interface dcache_ctrl_fsm_if #(
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2
);
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    // MEM stage and lookup
    logic              req_valid;
    logic              req_is_store;
    logic              req_uncached;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_way;
    logic              victim_dirty;

    // memory bridge responses
    logic              mem_rd_ready;
    logic              mem_wr_ready;

    // controller outputs
    logic              pipeline_ready;
    logic              rbuf_we;
    logic              en_r;
    logic              tag_we;
    logic              data_we;
    logic              dirty_set;
    logic              dirty_clr;
    logic [WAY_W-1:0]  way_sel;
    logic [BEAT_W-1:0] beat_idx;
    logic              is_data_from_mem;
    logic              mem_rd_valid;
    logic              mem_wr_valid;
    logic              mem_uncached;
    logic [1:0]        mem_addr_sel;

    modport slave (
        input  req_valid, req_is_store, req_uncached, hit, hit_way,
               victim_way, victim_dirty, mem_rd_ready, mem_wr_ready,
        output pipeline_ready, rbuf_we, en_r, tag_we, data_we, dirty_set,
               dirty_clr, way_sel, beat_idx, is_data_from_mem,
               mem_rd_valid, mem_wr_valid, mem_uncached, mem_addr_sel
    );

    modport master (
        output req_valid, req_is_store, req_uncached, hit, hit_way,
               victim_way, victim_dirty, mem_rd_ready, mem_wr_ready,
        input  pipeline_ready, rbuf_we, en_r, tag_we, data_we, dirty_set,
               dirty_clr, way_sel, beat_idx, is_data_from_mem,
               mem_rd_valid, mem_wr_valid, mem_uncached, mem_addr_sel
    );
endinterface

// File: rtl/dcache_ctrl_fsm.sv
// dcache_ctrl_fsm: blocking data-cache control FSM with victim selection,
// multi-beat line refill and uncached accesses.
// Optional feature macro: DCACHE_WRITE_BACK_EN
//   defined   -> write-back, write-allocate with dirty-victim eviction
//   undefined -> write-through, no-allocate; dirty outputs tied to 0
// Outputs are combinational from state, beat counter and inputs, and are
// all forced to 0 while rst is high.
module dcache_ctrl_fsm #(
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2
) (
    input  logic             clk,
    input  logic             rst,
    dcache_ctrl_fsm_if.slave bus
);
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB        = 3'd1,
        REFILL    = 3'd2,
        FILL_DONE = 3'd3,
        DIRECT    = 3'd4,
        WT_STORE  = 3'd5,
        UNC_RD    = 3'd6,
        UNC_WR    = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic              store_q, store_d;

    logic              lastBeat;
    logic              victimDirtyEff;

    logic              pipelineReady_o, rbufWe_o, enR_o, tagWe_o, dataWe_o;
    logic              dirtySet_o, dirtyClr_o, isDataFromMem_o;
    logic              memRdValid_o, memWrValid_o, memUncached_o;
    logic [WAY_W-1:0]  waySel_o;
    logic [1:0]        memAddrSel_o;

    assign lastBeat = (beat_q == LAST_BEAT);

`ifdef DCACHE_WRITE_BACK_EN
    assign victimDirtyEff = bus.victim_dirty;
`else
    // Without write-back the victim is never evicted, so its dirty bit is unused.
    logic unusedVictimDirty;
    assign unusedVictimDirty = bus.victim_dirty;
    assign victimDirtyEff    = 1'b0;
`endif

    // Next-state, beat counter, latched request and all control outputs.
    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        way_d           = way_q;
        store_d         = store_q;
        pipelineReady_o = 1'b0;
        rbufWe_o        = 1'b0;
        enR_o           = 1'b0;
        tagWe_o         = 1'b0;
        dataWe_o        = 1'b0;
        dirtySet_o      = 1'b0;
        dirtyClr_o      = 1'b0;
        isDataFromMem_o = 1'b0;
        memRdValid_o    = 1'b0;
        memWrValid_o    = 1'b0;
        memUncached_o   = 1'b0;
        memAddrSel_o    = 2'd0;
        waySel_o        = way_q;

        case (state_q)
            IDLE: begin
                waySel_o = '0;
                beat_d   = '0;
                if (!bus.req_valid) begin
                    rbufWe_o = 1'b1;
                    enR_o    = 1'b1;
                end else if (bus.req_uncached) begin
                    store_d = bus.req_is_store;
                    way_d   = bus.victim_way;
                    state_d = bus.req_is_store ? UNC_WR : UNC_RD;
                end else if (!bus.req_is_store) begin
                    if (bus.hit) begin
                        pipelineReady_o = 1'b1;
                        rbufWe_o        = 1'b1;
                        enR_o           = 1'b1;
                        waySel_o        = bus.hit_way;
                    end else begin
                        store_d = 1'b0;
                        way_d   = bus.victim_way;
                        state_d = victimDirtyEff ? WB : REFILL;
                    end
                end else begin
`ifdef DCACHE_WRITE_BACK_EN
                    if (bus.hit) begin
                        dataWe_o        = 1'b1;
                        dirtySet_o      = 1'b1;
                        pipelineReady_o = 1'b1;
                        rbufWe_o        = 1'b1;
                        enR_o           = 1'b1;
                        waySel_o        = bus.hit_way;
                    end else begin
                        store_d = 1'b1;
                        way_d   = bus.victim_way;
                        state_d = victimDirtyEff ? WB : REFILL;
                    end
`else
                    store_d = 1'b1;
                    if (bus.hit) begin
                        way_d   = bus.hit_way;
                        state_d = DIRECT;
                    end else begin
                        way_d   = bus.victim_way;
                        state_d = WT_STORE;
                    end
`endif
                end
            end

            WB: begin
                memWrValid_o = 1'b1;
                memAddrSel_o = 2'd1;
                if (bus.mem_wr_ready) begin
                    if (lastBeat) begin
                        beat_d  = '0;
                        state_d = REFILL;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            REFILL: begin
                memRdValid_o = 1'b1;
                memAddrSel_o = 2'd0;
                if (bus.mem_rd_ready) begin
                    dataWe_o = 1'b1;
                    if (lastBeat) begin
                        tagWe_o = 1'b1;
`ifdef DCACHE_WRITE_BACK_EN
                        dirtyClr_o = 1'b1;
`endif
                        beat_d  = '0;
                        state_d = FILL_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            FILL_DONE: begin
                isDataFromMem_o = 1'b1;
                pipelineReady_o = 1'b1;
                rbufWe_o        = 1'b1;
                enR_o           = 1'b1;
                if (store_q) begin
                    dataWe_o = 1'b1;
`ifdef DCACHE_WRITE_BACK_EN
                    dirtySet_o = 1'b1;
`endif
                end
                state_d = IDLE;
            end

            DIRECT: begin
                dataWe_o = 1'b1;
                state_d  = WT_STORE;
            end

            WT_STORE, UNC_WR: begin
                memWrValid_o  = 1'b1;
                memUncached_o = 1'b1;
                memAddrSel_o  = 2'd2;
                if (bus.mem_wr_ready) begin
                    pipelineReady_o = 1'b1;
                    rbufWe_o        = 1'b1;
                    enR_o           = 1'b1;
                    state_d         = IDLE;
                end
            end

            UNC_RD: begin
                memRdValid_o  = 1'b1;
                memUncached_o = 1'b1;
                memAddrSel_o  = 2'd2;
                if (bus.mem_rd_ready) begin
                    pipelineReady_o = 1'b1;
                    rbufWe_o        = 1'b1;
                    enR_o           = 1'b1;
                    isDataFromMem_o = 1'b1;
                    state_d         = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Reset silences every output in the same cycle it rises.
        if (rst) begin
            pipelineReady_o = 1'b0;
            rbufWe_o        = 1'b0;
            enR_o           = 1'b0;
            tagWe_o         = 1'b0;
            dataWe_o        = 1'b0;
            dirtySet_o      = 1'b0;
            dirtyClr_o      = 1'b0;
            isDataFromMem_o = 1'b0;
            memRdValid_o    = 1'b0;
            memWrValid_o    = 1'b0;
            memUncached_o   = 1'b0;
            memAddrSel_o    = 2'd0;
            waySel_o        = '0;
        end
    end

    // State, beat counter and latched request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            way_q   <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            way_q   <= way_d;
            store_q <= store_d;
        end
    end

    assign bus.pipeline_ready   = pipelineReady_o;
    assign bus.rbuf_we          = rbufWe_o;
    assign bus.en_r             = enR_o;
    assign bus.tag_we           = tagWe_o;
    assign bus.data_we          = dataWe_o;
    assign bus.dirty_set        = dirtySet_o;
    assign bus.dirty_clr        = dirtyClr_o;
    assign bus.way_sel          = waySel_o;
    assign bus.beat_idx         = beat_q;
    assign bus.is_data_from_mem = isDataFromMem_o;
    assign bus.mem_rd_valid     = memRdValid_o;
    assign bus.mem_wr_valid     = memWrValid_o;
    assign bus.mem_uncached     = memUncached_o;
    assign bus.mem_addr_sel     = memAddrSel_o;
endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// tb_dcache_ctrl_fsm: scoreboard bench for the data-cache control FSM.
// Each access pushes its expected completion record when driven; the record
// is popped and compared when pipeline_ready is observed.
module tb_dcache_ctrl_fsm;
    localparam int L    = 4;
    localparam int WAYS = 2;
`ifdef DCACHE_WRITE_BACK_EN
    localparam bit WBEN = 1'b1;
`else
    localparam bit WBEN = 1'b0;
`endif

    typedef struct {
        int lat;
        int data;
        int way;
        int chkWay;
        int dataWe;
        int tagWe;
        int dirtySet;
        int dirtyClr;
        int wbBeats;
        int rdBeats;
        int unc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];

    dcache_ctrl_fsm_if #(.LINE_WORDS(L), .WAYS(WAYS)) bus ();

    dcache_ctrl_fsm #(.LINE_WORDS(L), .WAYS(WAYS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Every comparison funnels through here.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // All outputs packed so reset silencing is a single comparison.
    function automatic int outVec();
        outVec = 32'({bus.pipeline_ready, bus.rbuf_we, bus.en_r, bus.tag_we,
                      bus.data_we, bus.dirty_set, bus.dirty_clr, bus.way_sel,
                      bus.beat_idx, bus.is_data_from_mem, bus.mem_rd_valid,
                      bus.mem_wr_valid, bus.mem_uncached, bus.mem_addr_sel});
    endfunction

    task automatic idleInputs();
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_uncached = 1'b0;
        bus.hit          = 1'b0;
        bus.hit_way      = '0;
        bus.victim_way   = '0;
        bus.victim_dirty = 1'b0;
        bus.mem_rd_ready = 1'b0;
        bus.mem_wr_ready = 1'b0;
    endtask

    // Drive one access, push its expectation, watch until completion.
    task automatic applyStimulus(input bit isStore, input bit unc, input bit hitIn,
                                 input int hitWay, input int victimWay,
                                 input bit vDirty, input int waits, input string name);
        exp_t e;
        int   dataWeCnt = 0, tagWeCnt = 0, dsCnt = 0, dcCnt = 0;
        int   wbB = 0, rdB = 0, uncSeen = 0, beatErr = 0;
        int   waitCnt = 0, cyc = 0, lat = 0, dataObs = 0, wayObs = 0;
        bit   done = 1'b0;

        e = '{lat:0, data:0, way:0, chkWay:0, dataWe:0, tagWe:0, dirtySet:0,
              dirtyClr:0, wbBeats:0, rdBeats:0, unc:0};
        if (unc) begin
            e.lat  = 1 + waits;
            e.data = isStore ? 0 : 1;
            e.unc  = 1;
        end else if (hitIn && !isStore) begin
            e.way    = hitWay;
            e.chkWay = 1;
        end else if (hitIn && isStore) begin
            e.way    = hitWay;
            e.chkWay = 1;
            e.dataWe = 1;
            if (WBEN) begin
                e.dirtySet = 1;
            end else begin
                e.lat = 2 + waits;
                e.unc = 1;
            end
        end else if (isStore && !WBEN) begin
            e.lat = 1 + waits;
            e.unc = 1;
        end else begin
            e.wbBeats  = (WBEN && vDirty) ? L : 0;
            e.rdBeats  = L;
            e.lat      = (e.wbBeats + L) * (waits + 1) + 1;
            e.dataWe   = L + (isStore ? 1 : 0);
            e.tagWe    = 1;
            e.dirtyClr = WBEN ? 1 : 0;
            e.dirtySet = isStore ? 1 : 0;
            e.data     = 1;
            e.way      = victimWay;
            e.chkWay   = 1;
        end
        sbQ.push_back(e);

        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                bus.req_valid    = 1'b1;
                bus.req_is_store = isStore;
                bus.req_uncached = unc;
                bus.hit          = hitIn;
                bus.hit_way      = hitWay[0:0];
                bus.victim_way   = victimWay[0:0];
                bus.victim_dirty = vDirty;
            end else begin
                bus.req_valid = 1'b0;
                bus.hit       = 1'b0;
            end
            #1;
            if (bus.mem_rd_valid || bus.mem_wr_valid) begin
                if (waitCnt == waits) begin
                    bus.mem_rd_ready = 1'b1;
                    bus.mem_wr_ready = 1'b1;
                    waitCnt = 0;
                end else begin
                    bus.mem_rd_ready = 1'b0;
                    bus.mem_wr_ready = 1'b0;
                    waitCnt++;
                end
            end else begin
                bus.mem_rd_ready = 1'b0;
                bus.mem_wr_ready = 1'b0;
            end
            @(negedge clk);
            if (bus.data_we)   dataWeCnt++;
            if (bus.dirty_set) dsCnt++;
            if (bus.dirty_clr) dcCnt++;
            if (bus.mem_uncached) uncSeen = 1;
            if (bus.tag_we) begin
                tagWeCnt++;
                if (int'(bus.beat_idx) != L - 1) beatErr++;
            end
            if (bus.mem_wr_valid && bus.mem_wr_ready && bus.mem_addr_sel == 2'd1) begin
                if (int'(bus.beat_idx) != wbB % L) beatErr++;
                wbB++;
            end
            if (bus.mem_rd_valid && bus.mem_rd_ready && bus.mem_addr_sel == 2'd0) begin
                if (int'(bus.beat_idx) != rdB % L || !bus.data_we) beatErr++;
                rdB++;
            end
            if (bus.pipeline_ready) begin
                done    = 1'b1;
                lat     = cyc;
                dataObs = int'(bus.is_data_from_mem);
                wayObs  = int'(bus.way_sel);
            end
            cyc++;
        end

        e = sbQ.pop_front();
        if (!done) begin
            checkOutput({name, " timeout"}, 0, 1);
        end else begin
            checkOutput({name, " latency"}, lat, e.lat);
            checkOutput({name, " is_data_from_mem"}, dataObs, e.data);
            if (e.chkWay != 0) checkOutput({name, " way_sel"}, wayObs, e.way);
            checkOutput({name, " data_we count"}, dataWeCnt, e.dataWe);
            checkOutput({name, " tag_we count"}, tagWeCnt, e.tagWe);
            checkOutput({name, " dirty_set count"}, dsCnt, e.dirtySet);
            checkOutput({name, " dirty_clr count"}, dcCnt, e.dirtyClr);
            checkOutput({name, " wb beats"}, wbB, e.wbBeats);
            checkOutput({name, " refill beats"}, rdB, e.rdBeats);
            checkOutput({name, " mem_uncached seen"}, uncSeen, e.unc);
            checkOutput({name, " beat order"}, beatErr, 0);
        end

        // The following cycle must be a quiet IDLE with the counter cleared.
        @(posedge clk);
        #1;
        idleInputs();
        @(negedge clk);
        checkOutput({name, " idle beat_idx"}, int'(bus.beat_idx), 0);
        checkOutput({name, " idle rdy/rbuf/en_r"},
                    int'({bus.pipeline_ready, bus.rbuf_we, bus.en_r}), 3);
    endtask

    // Abandon a refill at beat 2 with reset, then recover.
    task automatic resetMidRefill();
        bit found = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.hit        = 1'b0;
        bus.victim_way = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid    = 1'b0;
            bus.mem_rd_ready = 1'b1;
            #1;
            if (bus.mem_rd_valid && int'(bus.beat_idx) == 2) found = 1'b1;
        end
        checkOutput("reach refill beat 2", int'(found), 1);
        rst = 1'b1;
        #1;
        checkOutput("outputs on rst rise", outVec(), 0);
        idleInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("outputs held in rst", outVec(), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post-rst beat_idx", int'(bus.beat_idx), 0);
        checkOutput("post-rst idle rbuf/en_r", int'({bus.pipeline_ready, bus.rbuf_we, bus.en_r}), 3);
    endtask

    initial begin
        idleInputs();
        bus.req_valid = 1'b1;
        bus.hit       = 1'b1;
        bus.hit_way   = 1'b1;
        #12;
        checkOutput("reset outputs", outVec(), 0);
        checkOutput("reset beat_idx", int'(bus.beat_idx), 0);
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle no-req rdy/rbuf/en_r", int'({bus.pipeline_ready, bus.rbuf_we, bus.en_r}), 3);

        //            store unc hit hitW vicW vDirty waits name
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 0, "load hit w1");
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 0, "clean load miss");
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 2, "dirty load miss");
        applyStimulus(1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 2, "store hit");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1, 1'b1, 1, "store miss");
        applyStimulus(1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 0, "uncached load");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 1, "uncached store");
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1, "waited load miss");
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 0, "load hit w0");

        resetMidRefill();
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 0, "load hit after rst");

        checkOutput("scoreboard empty", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
